// File: rtl/rr_arbiter_if.sv
// rtl/rr_arbiter_if.sv - request/grant bundle between requesters and the round-robin arbiter
interface rr_arbiter_if #(
  parameter int N = 4
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           gnt_valid;
  logic           any_req;

  // Requester side: drives requests, observes grants.
  modport master (
    output req,
    input  gnt,
    input  gnt_id,
    input  gnt_valid,
    input  any_req
  );

  // Arbiter side: samples requests, issues grants.
  modport slave (
    input  req,
    output gnt,
    output gnt_id,
    output gnt_valid,
    output any_req
  );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with registered one-hot grant and bounded hold
module rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  rr_arbiter_if.slave bus
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;
  localparam int HW  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic           gnt_valid_q, gnt_valid_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HW-1:0]  hold_cnt_q, hold_cnt_d;

  logic           others_pending;

  // First requester at or after s, wrapping past N-1 back to 0.
  function automatic logic [IDW-1:0] search(input logic [N-1:0] r, input logic [IDW-1:0] s);
    logic [IDW-1:0] res;
    int             idx;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(s) + k;
      if (idx >= N) idx = idx - N;
      if (r[idx]) res = idx[IDW-1:0];
    end
    return res;
  endfunction

  // Successor index modulo N, valid for non-power-of-two N.
  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
    if (int'(i) == N - 1) return '0;
    else return i + IDW'(1);
  endfunction

  function automatic logic [N-1:0] onehot(input logic [IDW-1:0] i);
    return N'(1) << i;
  endfunction

  // Combinational request summary and registered grant outputs.
  always_comb begin
    bus.any_req   = |bus.req;
    bus.gnt       = gnt_q;
    bus.gnt_id    = gnt_id_q;
    bus.gnt_valid = gnt_valid_q;
  end

  // Next-state: idle pick, release/handoff, hold-limit preemption, or keep.
  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    gnt_id_d       = gnt_id_q;
    ptr_d          = ptr_q;
    hold_cnt_d     = hold_cnt_q;
    others_pending = |(bus.req & ~gnt_q);

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          gnt_id_d   = search(bus.req, ptr_q);
          gnt_d      = onehot(gnt_id_d);
          hold_cnt_d = HW'(1);
          state_d    = GRANT;
        end else begin
          gnt_d    = '0;
          gnt_id_d = '0;
        end
      end

      GRANT: begin
        if (!bus.req[gnt_id_q]) begin
          // Owner let go: advance past it and hand off in the same edge if anyone waits.
          ptr_d = next_idx(gnt_id_q);
          if (others_pending) begin
            gnt_id_d   = search(bus.req, next_idx(gnt_id_q));
            gnt_d      = onehot(gnt_id_d);
            hold_cnt_d = HW'(1);
          end else begin
            gnt_d      = '0;
            gnt_id_d   = '0;
            hold_cnt_d = '0;
            state_d    = IDLE;
          end
        end else if (others_pending && (MAX_HOLD != 0) && (hold_cnt_q == HW'(MAX_HOLD))) begin
          // Owner used its full quota while others wait: owner is last in the
          // search order from g+1, so someone else is always chosen.
          ptr_d      = next_idx(gnt_id_q);
          gnt_id_d   = search(bus.req, next_idx(gnt_id_q));
          gnt_d      = onehot(gnt_id_d);
          hold_cnt_d = HW'(1);
        end else if ((MAX_HOLD != 0) && (hold_cnt_q != HW'(MAX_HOLD))) begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end

      default: begin
        state_d  = IDLE;
        gnt_d    = '0;
        gnt_id_d = '0;
      end
    endcase

    gnt_valid_d = |gnt_d;
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end
endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - randomized and directed checks of rr_arbiter against a behavioural model
module tb_rr_arbiter;
  localparam int N  = 4;
  localparam int MH = 4;

  logic clk;
  logic rst_n;

  rr_arbiter_if #(.N(N)) bus ();

  rr_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: current owner (-1 = none), rotation start, cycles held.
  int m_owner;
  int m_ptr;
  int m_hold;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int s);
    for (int k = 0; k < N; k++) begin
      if (r[(s + k) % N]) return (s + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_gnt();
    logic [N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r);
    logic [N-1:0] others;
    if (m_owner < 0) begin
      if (r != '0) begin
        m_owner = rr_pick(r, m_ptr);
        m_hold  = 1;
      end
    end else begin
      others = r;
      others[m_owner] = 1'b0;
      if (!r[m_owner]) begin
        m_ptr = (m_owner + 1) % N;
        if (r != '0) begin
          m_owner = rr_pick(r, m_ptr);
          m_hold  = 1;
        end else begin
          m_owner = -1;
        end
      end else if (others != '0 && m_hold == MH) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = rr_pick(others, m_ptr);
        m_hold  = 1;
      end else if (m_hold < MH) begin
        m_hold++;
      end
    end
  endtask

  // One clock: drive req away from the edge, then compare outputs after it.
  task automatic cycle(input logic [N-1:0] r);
    logic [N-1:0] eg;
    @(negedge clk);
    bus.req = r;
    #1;
    check("any_req", 32'(bus.any_req), 32'(|r));
    model_step(r);
    @(posedge clk);
    #1;
    eg = exp_gnt();
    check("gnt", 32'(bus.gnt), 32'(eg));
    check("gnt_id", 32'(bus.gnt_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    check("gnt_valid", 32'(bus.gnt_valid), 32'(|eg));
    check("onehot0", 32'($onehot0(bus.gnt)), 32'd1);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.req = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_gnt_id", 32'(bus.gnt_id), 32'd0);
    check("rst_gnt_valid", 32'(bus.gnt_valid), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] r;
    rst_n   = 1'b0;
    bus.req = '0;

    // Idle pick from ptr=0.
    do_reset();
    cycle(4'b1010);
    check("t1_gnt", 32'(bus.gnt), 32'h2);
    check("t1_id", 32'(bus.gnt_id), 32'd1);

    // Release to idle, then ptr=1 shows up in the next pick.
    do_reset();
    cycle(4'b0001);
    cycle(4'b0000);
    check("t2_gnt", 32'(bus.gnt), 32'h0);
    cycle(4'b1111);
    check("t2_ptr_pick", 32'(bus.gnt), 32'h2);

    // Zero-bubble handoff.
    do_reset();
    cycle(4'b0010);
    cycle(4'b1001);
    check("t3_gnt", 32'(bus.gnt), 32'h8);
    check("t3_id", 32'(bus.gnt_id), 32'd3);

    // Fairness: everybody requesting, MH cycles each in order.
    do_reset();
    for (int c = 0; c < 17; c++) begin
      cycle(4'b1111);
      check("t4_fair", 32'(bus.gnt), 32'(1 << ((c / MH) % N)));
    end

    // Solo requester is never preempted.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      cycle(4'b0100);
      check("t5_solo", 32'(bus.gnt), 32'h4);
    end

    // Asynchronous reset mid-grant, then ptr back at 0.
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_async_gnt", 32'(bus.gnt), 32'h0);
    check("t6_async_valid", 32'(bus.gnt_valid), 32'd0);
    bus.req = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(4'b1111);
    check("t6_after", 32'(bus.gnt), 32'h1);

    // Randomized traffic; owner keeps its request most of the time to reach the hold limit.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      r = 4'($urandom_range(0, 15));
      if (m_owner >= 0 && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
      cycle(r);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
